// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register.
// Owns the fetch PC and the instruction-memory request/ready handshake.
// A single skid entry catches a response that arrives while ID is stalled,
// so fetch can park (HOLD) without dropping or refetching that instruction.
// Redirects replace the fetch PC, and flushes bubble the IF/ID slot.
module fetch_stage #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  // instruction memory
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  // pipeline control
  input  logic            stallD,
  input  logic            flushD,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  // IF/ID register toward decode
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pcPlus4D,
  output logic            validD,
  output logic [6:0]      opD,
  output logic [2:0]      funct3D,
  output logic [6:0]      funct7D,
  output logic [4:0]      rs1D,
  output logic [4:0]      rs2D,
  output logic [4:0]      rdD,
  output logic            fetch_busy
);

  // FETCH: request outstanding at pcF. HOLD: skid is full, fetch paused.
  typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pcF_q, pcF_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     instrD_q, instrD_d;
  logic [XLEN-1:0] pcD_q, pcD_d;
  logic            validD_q, validD_d;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_tgt;
  logic            id_load;
  logic [31:0]     id_load_instr;
  logic [XLEN-1:0] id_load_pc;
  logic            id_bubble;

  // Fetch targets are word aligned, so the low two bits of a redirect are dropped.
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign pc_inc       = pcF_q + XLEN'(4);

  // Request is killed combinationally during reset so no access escapes it.
  assign imem_req   = !reset && (state_q == S_FETCH);
  assign imem_addr  = pcF_q;
  assign fetch_busy = imem_req && !imem_ready;

  // Next-state logic for the fetch FSM, the fetch PC and the skid entry.
  // The IF/ID update is expressed as load/bubble requests and resolved below.
  always_comb begin
    state_d       = state_q;
    pcF_d         = pcF_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    id_load       = 1'b0;
    id_load_instr = imem_rdata;
    id_load_pc    = pcF_q;
    id_bubble     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (redirect) begin
          // Same-cycle response is on the wrong path and is dropped.
          pcF_d = redirect_tgt;
          if (!stallD) id_bubble = 1'b1;
        end else if (imem_ready && !stallD) begin
          id_load       = 1'b1;
          id_load_instr = imem_rdata;
          id_load_pc    = pcF_q;
          pcF_d         = pc_inc;
        end else if (imem_ready) begin
          // ID is stalled: park the response in the skid and stop fetching.
          skid_instr_d = imem_rdata;
          skid_pc_d    = pcF_q;
          pcF_d        = pc_inc;
          state_d      = S_HOLD;
        end else if (!stallD) begin
          id_bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          // Skid content is on the wrong path; leaving HOLD empties it.
          pcF_d   = redirect_tgt;
          state_d = S_FETCH;
          if (!stallD) id_bubble = 1'b1;
        end else if (!stallD) begin
          id_load       = 1'b1;
          id_load_instr = skid_instr_q;
          id_load_pc    = skid_pc_q;
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Flush wins over stall and over any load; fetch-side state is untouched.
    if (flushD) begin
      id_load   = 1'b0;
      id_bubble = 1'b1;
    end
  end

  // Resolve the IF/ID register update. A bubble keeps pcD so the slot still
  // reports where the pipeline was.
  always_comb begin
    instrD_d = instrD_q;
    pcD_d    = pcD_q;
    validD_d = validD_q;
    if (id_bubble) begin
      instrD_d = NOP_INSTR;
      validD_d = 1'b0;
    end else if (id_load) begin
      instrD_d = id_load_instr;
      pcD_d    = id_load_pc;
      validD_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pcF_q        <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      instrD_q     <= NOP_INSTR;
      pcD_q        <= '0;
      validD_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcF_q        <= pcF_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instrD_q     <= instrD_d;
      pcD_q        <= pcD_d;
      validD_q     <= validD_d;
    end
  end

  // Decode-side views of the IF/ID register.
  assign instrD   = instrD_q;
  assign pcD      = pcD_q;
  assign validD   = validD_q;
  assign pcPlus4D = pcD_q + XLEN'(4);
  assign opD      = instrD_q[6:0];
  assign rdD      = instrD_q[11:7];
  assign funct3D  = instrD_q[14:12];
  assign rs1D     = instrD_q[19:15];
  assign rs2D     = instrD_q[24:20];
  assign funct7D  = instrD_q[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus pushes every instruction
// it expects decode to consume; a negedge monitor pops one each time ID
// hands an instruction on (valid, not stalled, not flushed).
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stallD, flushD, redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instrD;
  logic [63:0] pcD, pcPlus4D;
  logic        validD;
  logic [6:0]  opD, funct7D;
  logic [2:0]  funct3D;
  logic [4:0]  rs1D, rs2D, rdD;
  logic        fetch_busy;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(64), .RESET_PC(64'h1000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stallD(stallD), .flushD(flushD),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instrD(instrD), .pcD(pcD), .pcPlus4D(pcPlus4D), .validD(validD),
    .opD(opD), .funct3D(funct3D), .funct7D(funct7D),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .fetch_busy(fetch_busy)
  );

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] mem(input logic [63:0] a);
    return {a[29:0], 2'b11} ^ 32'h1234_5600;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [63:0] pc);
    exp_t e;
    e.instr = mem(pc);
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an instruction leaves ID when valid and neither stalled nor flushed.
  always @(negedge clk) begin
    if (!reset && validD && !stallD && !flushD) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h instr %h, expected none", pcD, instrD);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_instr", {32'b0, instrD}, {32'b0, mon_e.instr});
        chk("mon_pc", pcD, mon_e.pc);
        chk("mon_pc4", pcPlus4D, mon_e.pc + 64'd4);
        chk("mon_rd", {59'b0, rdD}, {59'b0, mon_e.instr[11:7]});
        chk("mon_op", {57'b0, opD}, {57'b0, mon_e.instr[6:0]});
        chk("mon_f7", {57'b0, funct7D}, {57'b0, mon_e.instr[31:25]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_ready = 1'b1; stallD = 1'b0; flushD = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_req", {63'b0, imem_req}, 64'd0);
    chk("rst_valid", {63'b0, validD}, 64'd0);
    chk("rst_instr", {32'b0, instrD}, {32'b0, NOP});
    chk("rst_pcD", pcD, 64'd0);
    chk("rst_addr", imem_addr, 64'h1000);
    chk("rst_busy", {63'b0, fetch_busy}, 64'd0);

    // zero-wait streaming A, B, C
    cyc(); reset = 1'b0; expect_fetch(64'h1000);
    @(negedge clk); chk("c0_addr", imem_addr, 64'h1000); chk("c0_req", {63'b0, imem_req}, 64'd1);
    cyc(); expect_fetch(64'h1004);
    @(negedge clk); chk("c1_addr", imem_addr, 64'h1004);
    cyc(); expect_fetch(64'h1008);
    @(negedge clk); chk("c2_valid", {63'b0, validD}, 64'd1);

    // memory wait states: three cycles not ready at 0x100C
    cyc(); imem_ready = 1'b0;
    @(negedge clk); chk("w0_busy", {63'b0, fetch_busy}, 64'd1); chk("w0_addr", imem_addr, 64'h100C);
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      chk("w_busy", {63'b0, fetch_busy}, 64'd1);
      chk("w_valid", {63'b0, validD}, 64'd0);
      chk("w_instr", {32'b0, instrD}, {32'b0, NOP});
    end
    cyc(); imem_ready = 1'b1; expect_fetch(64'h100C);
    @(negedge clk); chk("w3_valid", {63'b0, validD}, 64'd0); chk("w3_busy", {63'b0, fetch_busy}, 64'd0);

    // stall while a response arrives: response goes to the skid
    cyc(); stallD = 1'b1; expect_fetch(64'h1010);
    @(negedge clk); chk("s0_addr", imem_addr, 64'h1010); chk("s0_pcD", pcD, 64'h100C);
    cyc();
    @(negedge clk); chk("s1_req", {63'b0, imem_req}, 64'd0); chk("s1_pcD", pcD, 64'h100C);
    chk("s1_valid", {63'b0, validD}, 64'd1);
    cyc(); stallD = 1'b0;
    @(negedge clk); chk("s2_req", {63'b0, imem_req}, 64'd0);
    cyc(); expect_fetch(64'h1014);
    @(negedge clk); chk("s3_addr", imem_addr, 64'h1014); chk("s3_pcD", pcD, 64'h1010);

    // redirect to a misaligned target while the response at 0x1018 is returned
    cyc(); redirect = 1'b1; redirect_pc = 64'h2003;
    @(negedge clk); chk("r0_addr", imem_addr, 64'h1018);
    cyc(); redirect = 1'b0; expect_fetch(64'h2000);
    @(negedge clk); chk("r1_addr", imem_addr, 64'h2000); chk("r1_valid", {63'b0, validD}, 64'd0);

    // stall fills the skid, then flush+stall kills the instruction in ID
    cyc(); stallD = 1'b1; expect_fetch(64'h2004);
    @(negedge clk); chk("f0_pcD", pcD, 64'h2000); chk("f0_valid", {63'b0, validD}, 64'd1);
    cyc(); flushD = 1'b1;
    void'(exp_q.pop_front());   // the 0x2000 instruction is flushed out of ID
    @(negedge clk); chk("f1_pcD", pcD, 64'h2000); chk("f1_req", {63'b0, imem_req}, 64'd0);
    cyc(); flushD = 1'b0;
    @(negedge clk); chk("f2_valid", {63'b0, validD}, 64'd0);
    chk("f2_instr", {32'b0, instrD}, {32'b0, NOP});
    chk("f2_pcD", pcD, 64'h2000); chk("f2_req", {63'b0, imem_req}, 64'd0);
    cyc(); stallD = 1'b0;
    @(negedge clk); chk("f3_req", {63'b0, imem_req}, 64'd0);

    // redirect to the top word; the fetch there wraps pcF to 0
    cyc(); redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk); chk("x0_addr", imem_addr, 64'h2008); chk("x0_pcD", pcD, 64'h2004);
    cyc(); redirect = 1'b0; expect_fetch(64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk); chk("x1_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("x1_valid", {63'b0, validD}, 64'd0);
    cyc(); imem_ready = 1'b0;
    @(negedge clk); chk("x2_addr", imem_addr, 64'd0);
    chk("x2_pcD", pcD, 64'hFFFF_FFFF_FFFF_FFFC); chk("x2_pc4", pcPlus4D, 64'd0);

    // reset while parked in HOLD discards the skid
    cyc(); stallD = 1'b1; imem_ready = 1'b1;
    @(negedge clk); chk("h0_valid", {63'b0, validD}, 64'd0);
    cyc(); reset = 1'b1; stallD = 1'b0;
    @(negedge clk); chk("h1_req", {63'b0, imem_req}, 64'd0);
    cyc();
    @(negedge clk); chk("h2_addr", imem_addr, 64'h1000);
    chk("h2_valid", {63'b0, validD}, 64'd0); chk("h2_req", {63'b0, imem_req}, 64'd0);
    cyc(); reset = 1'b0; imem_ready = 1'b0;
    @(negedge clk); chk("h3_req", {63'b0, imem_req}, 64'd1); chk("h3_busy", {63'b0, fetch_busy}, 64'd1);
    cyc();
    @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
